ctrl_seq: RTL and testbench

Multi-cycle control sequencer for the 9-bit datapath. Replaces single-cycle, purely combinational decoding with a FETCH/EXEC/MEMWAIT/HALT state machine. Key behaviours:
- Latches each instruction word into an internal instruction register.
- Gates every write/jump strobe to exactly one cycle per instruction.
- Stretches loads across a parametrised data-memory read latency.
- Holds Done sticky in HALT and counts retired instructions.

It sits between instruction memory (mach_code) and the register file, ALU, data memory and program-counter blocks.

---
 rtl/ctrl_pkg.sv | 44 ++++
 rtl/ctrl_decode.sv | 71 +++++++
 rtl/ctrl_seq.sv | 157 +++++++++++++++
 tb/tb_ctrl_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants, state encoding and the decoded-control bundle for the
// multi-cycle control sequencer.
package ctrl_pkg;

  // Major opcode field IR[8:6]
  localparam logic [2:0] OP_BR  = 3'b100;
  localparam logic [2:0] OP_ST  = 3'b101;
  localparam logic [2:0] OP_LD  = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

  localparam logic [8:0] HALT_CODE = 9'b011111111;

  // Fixed register indices and ALU code
  localparam logic [2:0] REG_ADDR = 3'd6;   // address / load-constant register
  localparam logic [2:0] REG_ST   = 3'd7;   // store-data register
  localparam logic [2:0] ALU_PASS = 3'b111; // ALU passes operand A

  // Width of the MEMWAIT cycle counter (covers latencies 1..4)
  localparam int unsigned WAIT_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    MEMWAIT,
    HALT
  } state_e;

  // Raw controls produced by the decoder, before state gating
  typedef struct packed {
    logic [2:0] aluop;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] wd;
    logic [4:0] ldc_val;
    logic       wen_r;
    logic       wen_d;
    logic       ren_d;
    logic       mem_to_reg;
    logic       jen;
    logic       ldcen;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: IR -> raw control bundle, branch target
// and the load/halt flags the sequencer uses to pick the next state.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int JW = 8
) (
  input  logic [8:0]    ir_i,
  output ctrl_t         ctrl_o,
  output logic [JW-1:0] jptr_o,
  output logic          is_load_o,
  output logic          is_halt_o
);

  // Priority decode; halt is checked before the opcode field.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    ctrl_o    = '0;
    jptr_o    = '0;
    is_load_o = 1'b0;
    is_halt_o = 1'b0;

    if (ir_i == HALT_CODE) begin
      is_halt_o = 1'b1;
    end else begin
      case (ir_i[8:6])
        OP_BR: begin
          ctrl_o.jen = 1'b1;
          jptr_o     = JW'(ir_i[5:0]);
        end
        OP_LD: begin
          if (!ir_i[0]) begin
            // Load register: write-back happens later, in the final MEMWAIT cycle
            ctrl_o.ren_d      = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
            ctrl_o.ra         = REG_ADDR;
            ctrl_o.wd         = ir_i[5:3];
            is_load_o         = 1'b1;
          end else begin
            // Load constant into the address register
            ctrl_o.ldcen   = 1'b1;
            ctrl_o.ldc_val = ir_i[5:1];
            ctrl_o.wd      = REG_ADDR;
            ctrl_o.wen_r   = 1'b1;
          end
        end
        OP_ST: begin
          ctrl_o.wen_d = 1'b1;
          ctrl_o.ra    = REG_ST;
          ctrl_o.rb    = ir_i[5:3];
        end
        OP_MOV: begin
          ctrl_o.aluop = ALU_PASS;
          ctrl_o.ra    = ir_i[5:3];
          ctrl_o.wd    = ir_i[2:0];
          ctrl_o.wen_r = 1'b1;
        end
        default: begin
          // R-type: ALU op in IR[7:5], A from the low register bank
          ctrl_o.aluop = ir_i[7:5];
          ctrl_o.ra    = {1'b0, ir_i[4:3]};
          ctrl_o.rb    = ir_i[2:0];
          ctrl_o.wd    = ir_i[2:0];
          ctrl_o.wen_r = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer: FETCH/EXEC/MEMWAIT/HALT FSM that latches the
// instruction word, gates decoded strobes to one cycle per instruction,
// stretches loads over MEM_LAT cycles and counts retired instructions.
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int JW      = 8,
  parameter int CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [8:0]       mach_code,
  output logic             InstrReq,
  output logic             PcEn,
  output logic [2:0]       Aluop,
  output logic [2:0]       Ra,
  output logic [2:0]       Rb,
  output logic [2:0]       Wd,
  output logic [4:0]       LdcVal,
  output logic [JW-1:0]    Jptr,
  output logic             WenR,
  output logic             WenD,
  output logic             RenD,
  output logic             MemToReg,
  output logic             Jen,
  output logic             Ldcen,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] InstCnt
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_LAT - 1);

  state_e              state_q, state_d;
  logic [8:0]          ir_q, ir_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  ctrl_t               raw_ctrl, ctrl;
  logic [JW-1:0]       raw_jptr, jptr;
  logic                is_load, is_halt;
  logic                retire;

  ctrl_decode #(.JW(JW)) u_decode (
    .ir_i      (ir_q),
    .ctrl_o    (raw_ctrl),
    .jptr_o    (raw_jptr),
    .is_load_o (is_load),
    .is_halt_o (is_halt)
  );

  // State, instruction register, MEMWAIT counter and retire counter
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (Reset) begin
      state_q <= IDLE;
      ir_q    <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and state-gated outputs
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    wait_d   = wait_q;
    cnt_d    = cnt_q;
    ctrl     = '0;
    jptr     = '0;
    InstrReq = 1'b0;
    PcEn     = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    retire   = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = FETCH;
          cnt_d   = '0;
        end
      end
      FETCH: begin
        InstrReq = 1'b1;
        Busy     = 1'b1;
        ir_d     = mach_code;
        state_d  = EXEC;
      end
      EXEC: begin
        Busy = 1'b1;
        ctrl = raw_ctrl;
        jptr = raw_jptr;
        if (is_load) begin
          wait_d  = '0;
          state_d = MEMWAIT;
        end else begin
          PcEn    = !is_halt;
          retire  = 1'b1;
          state_d = is_halt ? HALT : FETCH;
        end
      end
      MEMWAIT: begin
        // Hold the load's read controls until the data arrives
        Busy            = 1'b1;
        ctrl.ren_d      = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.ra         = raw_ctrl.ra;
        ctrl.wd         = raw_ctrl.wd;
        if (wait_q == WAIT_LAST) begin
          ctrl.wen_r = 1'b1;
          PcEn       = 1'b1;
          retire     = 1'b1;
          state_d    = FETCH;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      HALT: begin
        Done = 1'b1;
        if (Start) begin
          state_d = FETCH;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Saturating retire count
    if (retire && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign Aluop    = ctrl.aluop;
  assign Ra       = ctrl.ra;
  assign Rb       = ctrl.rb;
  assign Wd       = ctrl.wd;
  assign LdcVal   = ctrl.ldc_val;
  assign WenR     = ctrl.wen_r;
  assign WenD     = ctrl.wen_d;
  assign RenD     = ctrl.ren_d;
  assign MemToReg = ctrl.mem_to_reg;
  assign Jen      = ctrl.jen;
  assign Ldcen    = ctrl.ldcen;
  assign Jptr     = jptr;
  assign InstCnt  = cnt_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Randomized self-checking bench for ctrl_seq. Three instances with different
// load latency / counter width share one input stream; each is compared every
// cycle against an instruction-level model (instruction = fetch cycle followed
// by its execute cycles).
module tb_ctrl_seq;

  localparam int N = 3;

  function automatic int lat_of(input int i);
    case (i)
      0:       return 3;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int cw_of(input int i);
    return (i == 0) ? 2 : 16;
  endfunction

  typedef struct packed {
    logic        instr_req;
    logic        pc_en;
    logic [2:0]  aluop;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [2:0]  wd;
    logic [4:0]  ldc_val;
    logic [7:0]  jptr;
    logic        wen_r;
    logic        wen_d;
    logic        ren_d;
    logic        mem_to_reg;
    logic        jen;
    logic        ldcen;
    logic        busy;
    logic        done;
    logic [15:0] cnt;
  } obs_t;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [8:0] mach_code;
  obs_t       obs [N];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LAT = lat_of(g);
    localparam int CW  = cw_of(g);
    logic          instr_req, pc_en, wen_r, wen_d, ren_d, mem_to_reg;
    logic          jen, ldcen, busy, done;
    logic [2:0]    aluop, ra, rb, wd;
    logic [4:0]    ldc_val;
    logic [7:0]    jptr;
    logic [CW-1:0] inst_cnt;

    ctrl_seq #(.MEM_LAT(LAT), .JW(8), .CNT_W(CW)) u_dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Start     (Start),
      .mach_code (mach_code),
      .InstrReq  (instr_req),
      .PcEn      (pc_en),
      .Aluop     (aluop),
      .Ra        (ra),
      .Rb        (rb),
      .Wd        (wd),
      .LdcVal    (ldc_val),
      .Jptr      (jptr),
      .WenR      (wen_r),
      .WenD      (wen_d),
      .RenD      (ren_d),
      .MemToReg  (mem_to_reg),
      .Jen       (jen),
      .Ldcen     (ldcen),
      .Busy      (busy),
      .Done      (done),
      .InstCnt   (inst_cnt)
    );

    assign obs[g] = {instr_req, pc_en, aluop, ra, rb, wd, ldc_val, jptr,
                     wen_r, wen_d, ren_d, mem_to_reg, jen, ldcen, busy, done,
                     16'(inst_cnt)};
  end

  // ---------------- reference model ----------------
  bit         m_run  [N];  // inside an instruction (fetch or execute part)
  bit         m_done [N];  // halted
  int         m_pos  [N];  // cycle index within the current instruction
  logic [8:0] m_ir   [N];
  int         m_cnt  [N];

  function automatic bit is_ld(input logic [8:0] w);
    return (w[8:6] == 3'b110) && !w[0];
  endfunction

  function automatic int instr_len(input int i, input logic [8:0] w);
    return is_ld(w) ? 2 + lat_of(i) : 2;
  endfunction

  function automatic obs_t expect_of(input int i);
    obs_t       e;
    logic [8:0] w;
    bit         last;
    e       = '0;
    w       = m_ir[i];
    e.cnt   = 16'(m_cnt[i]);
    e.busy  = m_run[i];
    e.done  = !m_run[i] && m_done[i];
    if (m_run[i] && m_pos[i] == 0) e.instr_req = 1'b1;
    if (m_run[i] && m_pos[i] >= 1) begin
      last = (m_pos[i] == instr_len(i, w) - 1);
      if (w == 9'b011111111) begin
        // halt: nothing asserted
      end else if (w[8:6] == 3'b100) begin
        e.jen = 1'b1; e.jptr = {2'b00, w[5:0]}; e.pc_en = 1'b1;
      end else if (is_ld(w)) begin
        e.ren_d = 1'b1; e.mem_to_reg = 1'b1; e.ra = 3'd6; e.wd = w[5:3];
        e.wen_r = last; e.pc_en = last;
      end else if (w[8:6] == 3'b110) begin
        e.ldcen = 1'b1; e.ldc_val = w[5:1]; e.wd = 3'd6;
        e.wen_r = 1'b1; e.pc_en = 1'b1;
      end else if (w[8:6] == 3'b101) begin
        e.wen_d = 1'b1; e.ra = 3'd7; e.rb = w[5:3]; e.pc_en = 1'b1;
      end else if (w[8:6] == 3'b111) begin
        e.aluop = 3'b111; e.ra = w[5:3]; e.wd = w[2:0];
        e.wen_r = 1'b1; e.pc_en = 1'b1;
      end else begin
        e.aluop = w[7:5]; e.ra = {1'b0, w[4:3]}; e.rb = w[2:0];
        e.wd = w[2:0]; e.wen_r = 1'b1; e.pc_en = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic model_step(input int i, input logic r, input logic s,
                            input logic [8:0] mc);
    int cmax;
    cmax = (1 << cw_of(i)) - 1;
    if (r) begin
      m_run[i] = 0; m_done[i] = 0; m_pos[i] = 0; m_ir[i] = '0; m_cnt[i] = 0;
    end else if (!m_run[i]) begin
      if (s) begin
        m_run[i] = 1; m_done[i] = 0; m_pos[i] = 0; m_cnt[i] = 0;
      end
    end else if (m_pos[i] == 0) begin
      m_ir[i]  = mc;
      m_pos[i] = 1;
    end else if (m_pos[i] == instr_len(i, m_ir[i]) - 1) begin
      if (m_cnt[i] < cmax) m_cnt[i] = m_cnt[i] + 1;
      if (m_ir[i] == 9'b011111111) begin
        m_run[i] = 0; m_done[i] = 1;
      end else begin
        m_pos[i] = 0;
      end
    end else begin
      m_pos[i] = m_pos[i] + 1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, want);
    end
  endtask

  task automatic compare_all();
    obs_t e, o;
    for (int i = 0; i < N; i++) begin
      e = expect_of(i);
      o = obs[i];
      check($sformatf("dut%0d.InstrReq", i), 32'(o.instr_req),  32'(e.instr_req));
      check($sformatf("dut%0d.PcEn", i),     32'(o.pc_en),      32'(e.pc_en));
      check($sformatf("dut%0d.Aluop", i),    32'(o.aluop),      32'(e.aluop));
      check($sformatf("dut%0d.Ra", i),       32'(o.ra),         32'(e.ra));
      check($sformatf("dut%0d.Rb", i),       32'(o.rb),         32'(e.rb));
      check($sformatf("dut%0d.Wd", i),       32'(o.wd),         32'(e.wd));
      check($sformatf("dut%0d.LdcVal", i),   32'(o.ldc_val),    32'(e.ldc_val));
      check($sformatf("dut%0d.Jptr", i),     32'(o.jptr),       32'(e.jptr));
      check($sformatf("dut%0d.WenR", i),     32'(o.wen_r),      32'(e.wen_r));
      check($sformatf("dut%0d.WenD", i),     32'(o.wen_d),      32'(e.wen_d));
      check($sformatf("dut%0d.RenD", i),     32'(o.ren_d),      32'(e.ren_d));
      check($sformatf("dut%0d.MemToReg", i), 32'(o.mem_to_reg), 32'(e.mem_to_reg));
      check($sformatf("dut%0d.Jen", i),      32'(o.jen),        32'(e.jen));
      check($sformatf("dut%0d.Ldcen", i),    32'(o.ldcen),      32'(e.ldcen));
      check($sformatf("dut%0d.Busy", i),     32'(o.busy),       32'(e.busy));
      check($sformatf("dut%0d.Done", i),     32'(o.done),       32'(e.done));
      check($sformatf("dut%0d.InstCnt", i),  32'(o.cnt),        32'(e.cnt));
    end
  endtask

  // One clock: compare current outputs, drive inputs, advance the model
  task automatic cycle(input logic r, input logic s, input logic [8:0] mc);
    @(negedge Clk);
    compare_all();
    Reset     = r;
    Start     = s;
    mach_code = mc;
    @(posedge Clk);
    for (int i = 0; i < N; i++) model_step(i, r, s, mc);
  endtask

  function automatic logic [8:0] noise();
    return 9'($urandom);
  endfunction

  function automatic logic [8:0] rand_word();
    case ($urandom_range(0, 7))
      0:       return 9'b011111111;
      1:       return {3'b110, 5'($urandom), 1'b0};
      default: return 9'($urandom);
    endcase
  endfunction

  // Run one instruction on the MEM_LAT=3 instance: fetch, then execute cycles
  task automatic run_word(input logic [8:0] w, input int exec_cycles);
    cycle(1'b0, 1'b0, w);
    for (int k = 0; k < exec_cycles; k++) cycle(1'b0, 1'b0, noise());
  endtask

  initial begin
    Reset     = 1'b1;
    Start     = 1'b0;
    mach_code = '0;
    @(posedge Clk);
    for (int i = 0; i < N; i++) model_step(i, 1'b1, 1'b0, 9'h0);

    // Directed sequence from the test plan (aligned to the MEM_LAT=3 instance)
    cycle(1'b1, 1'b0, 9'h0);
    cycle(1'b0, 1'b1, noise());          // IDLE + Start
    run_word(9'b000101011, 1);           // R-type
    run_word(9'b110010000, 4);           // load: EXEC + 3 MEMWAIT
    run_word(9'b100101010, 1);           // branch
    run_word(9'b101011000, 1);           // store
    run_word(9'b110101011, 1);           // load constant
    run_word(9'b011111111, 1);           // halt
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, noise());
    cycle(1'b0, 1'b1, noise());          // restart from HALT
    run_word(9'b111010101, 1);           // move
    cycle(1'b0, 1'b0, 9'b110011000);     // fetch load
    cycle(1'b0, 1'b0, noise());          // EXEC
    cycle(1'b0, 1'b0, noise());          // MEMWAIT 1
    cycle(1'b1, 1'b0, noise());          // reset during MEMWAIT 2
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, noise());
    cycle(1'b0, 1'b1, noise());
    for (int k = 0; k < 5; k++) begin
      run_word(9'b000011010, 1);         // five R-types: saturates 2-bit count
    end

    // Randomized phase
    for (int k = 0; k < 2500; k++) begin
      cycle(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), rand_word());
    end

    @(negedge Clk);
    compare_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
